fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage, directly upstream of the ROM / instruction bus: a Wishbone master that reads
//  one 64-bit instruction per bus cycle from the current PC and queues it in a 2-entry buffer. The buffer
//  feeds decode through a valid/ready handshake. Supports PC redirect (jump/call/return) with flush,
//  and bus-error faulting.
// PARAMETERS
//  ADR_WIDTH   16  width of fetch_adr_o / PC (byte address)
//  DAT_WIDTH   64  instruction / bus data width
//  RESET_PC    0   first fetch address after reset; must be a multiple of 8
//  DEPTH       2   instruction buffer entries (power of 2, >=2)
// PORTS
//  clk_i         in   1          clock, all state on rising edge
//  rst_n_i       in   1          asynchronous, active-low reset
//  fetch_cyc_o   out  1          WB cycle
//  fetch_stb_o   out  1          WB strobe (always equal to fetch_cyc_o)
//  fetch_we_o    out  1          WB write enable, tied 0
//  fetch_adr_o   out  ADR_WIDTH  WB address = request PC
//  fetch_dat_o   out  DAT_WIDTH  WB write data, tied 0
//  fetch_dat_i   in   DAT_WIDTH  WB read data
//  fetch_ack_i   in   1          WB ack (slave gates it with stb)
//  fetch_err_i   in   1          WB error
//  ins_valid_o   out  1          buffer head valid
//  ins_o         out  DAT_WIDTH  head instruction
//  ins_pc_o      out  ADR_WIDTH  head instruction address
//  ins_err_o     out  1          head entry is a bus fault (ins_o = 0)
//  ins_ready_i   in   1          decode accepts head this cycle
//  redir_i       in   1          redirect request (1-cycle pulse)
//  redir_pc_i    in   ADR_WIDTH  redirect target, bits [2:0] ignored (forced 0)
// BEHAVIOUR
//  Reset (async, rst_n_i low): all outputs 0, state IDLE, pc=RESET_PC, buffer empty, discard=0.
//  States:
//   - IDLE: if reserve<DEPTH and !redir_i -> REQ; drive cyc/stb=1, adr=pc.
//     reserve = occupancy + in-flight.
//   - REQ: cyc/stb held until ack or err sampled high.
//     - ack: push {dat_i,pc,0} unless discard; pc+=8 (wraps mod 2^ADR_WIDTH); -> GAP.
//     - err: push {0,pc,1} unless discard; -> FAULT, or -> GAP if discard.
//     - Both high: err wins.
//   - GAP: cyc/stb=0 for exactly one cycle (the slave returns to idle only after seeing stb low) -> IDLE.
//     Minimum 3 cycles per fetch: stb, ack, gap.
//   - FAULT: no bus activity. Leaves only on redir_i -> IDLE.
//  Handshake: pop when ins_valid_o & ins_ready_i. Push and pop in the same cycle are both allowed.
//   The buffer never overflows because a request is issued only when a slot is reserved.
//  ins_* are driven from buffer head registers. A push into an empty buffer is visible the next cycle.
//  Redirect (redir_i=1), highest priority:
//   - Buffer is flushed the same cycle; any concurrent pop is ignored. pc <= redir_pc_i & ~7.
//   - If in REQ: stb stays until ack/err, discard=1, and the returning data is dropped.
//     discard clears on that ack/err, then GAP -> IDLE fetches the new pc.
//   - From IDLE, GAP or FAULT: next state IDLE; the new pc is fetched the cycle after.
//   - Redirect during the discard window: updates pc only; discard stays 1.
//  Latency (empty buffer, zero-wait slave): stb cycle N, ack N+1, ins_valid_o at N+2.
//  Decode stall (ready=0) with full buffer: fetching pauses in IDLE with cyc=0.
//  fetch_we_o=0 always; a write fault is impossible by construction.
// STRUCTURE
//  Shared include (config.v / utils.v): DAT_WIDTH, ADR_WIDTH, FETCH_STATE_* encodings.
//  WB master port macro: wishbone.v.
//  One sub-module, fetch_fifo: synchronous DEPTH x (DAT_WIDTH+ADR_WIDTH+1), flush input,
//   registered head, count output.
//  Top: FSM, pc and discard registers, reserve computation.
// TESTING
//  1 Reset, ROM model (ack 1 cycle after stb, needs stb low to rearm), ready=1
//    -> adr 0x0,0x8,0x10 on cycles 1,4,7; first ins_valid_o on cycle 3 with ins_pc_o=0.
//  2 ready=0 for 20 cycles -> exactly 2 fetches issued, then cyc=0.
//    Release ready -> entries pc 0x0,0x8 in order, fetch resumes at 0x10.
//  3 redir_i pc=0x48 while in REQ for 0x10 -> 0x10 data never appears on ins_*, bus completes then gap,
//    next adr=0x48; redir pc=0x4d -> adr 0x48.
//  4 Slave asserts err at 0x18 -> one entry with ins_err_o=1, ins_o=0, pc=0x18; bus idle thereafter.
//    redir to 0x0 -> fetch restarts.
//  5 rst_n_i low mid-REQ (asynchronous, between edges) -> cyc/stb and ins_valid_o drop immediately.
//    Release -> first fetch at RESET_PC.
//  6 pc=0xFFF8 (ADR_WIDTH 16) fetch -> next adr 0x0000. Push+pop same cycle with buffer full
//    -> count stays 2, no lost or duplicated instruction.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int FETCH_ADR_WIDTH = 16;
  localparam int FETCH_DAT_WIDTH = 64;
  localparam int FETCH_DEPTH     = 2;
  localparam int INS_BYTES       = 8;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_GAP   = 2'd2,
    FETCH_FAULT = 2'd3
  } fetch_state_e;

  function automatic int entry_width(input int dat_w, input int adr_w);
    return dat_w + adr_w + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer: register storage, head read straight from the
// entry registers, synchronous flush that overrides push/pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int W     = entry_width(FETCH_DAT_WIDTH, FETCH_ADR_WIDTH),
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // when full, a simultaneous push lands in the slot the pop is vacating
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: Wishbone read master feeding a small buffer that
// decode drains through a valid/ready handshake; handles redirect and bus faults.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          ADR_WIDTH = FETCH_ADR_WIDTH,
  parameter int          DAT_WIDTH = FETCH_DAT_WIDTH,
  parameter int unsigned RESET_PC  = 0,
  parameter int          DEPTH     = FETCH_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  output logic                 fetch_cyc_o,
  output logic                 fetch_stb_o,
  output logic                 fetch_we_o,
  output logic [ADR_WIDTH-1:0] fetch_adr_o,
  output logic [DAT_WIDTH-1:0] fetch_dat_o,
  input  logic [DAT_WIDTH-1:0] fetch_dat_i,
  input  logic                 fetch_ack_i,
  input  logic                 fetch_err_i,
  output logic                 ins_valid_o,
  output logic [DAT_WIDTH-1:0] ins_o,
  output logic [ADR_WIDTH-1:0] ins_pc_o,
  output logic                 ins_err_o,
  input  logic                 ins_ready_i,
  input  logic                 redir_i,
  input  logic [ADR_WIDTH-1:0] redir_pc_i
);

  localparam int EW = entry_width(DAT_WIDTH, ADR_WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADR_WIDTH-1:0] PC_RST   = ADR_WIDTH'(RESET_PC);
  localparam logic [ADR_WIDTH-1:0] PC_STEP  = ADR_WIDTH'(INS_BYTES);
  localparam logic [ADR_WIDTH-1:0] PC_ALIGN = ~ADR_WIDTH'(INS_BYTES - 1);

  typedef struct packed {
    logic [DAT_WIDTH-1:0] ins;
    logic [ADR_WIDTH-1:0] pc;
    logic                 err;
  } fetch_entry_t;

  fetch_state_e         state;
  logic [ADR_WIDTH-1:0] pc;
  logic                 discard;

  logic [CW-1:0]        count;
  logic [CW:0]          reserve;
  logic                 launch_ok;
  logic                 bus_done;
  logic                 push;
  logic                 pop;
  logic [ADR_WIDTH-1:0] redir_pc_al;
  fetch_entry_t         push_entry;
  fetch_entry_t         head;

  assign fetch_stb_o = fetch_cyc_o;
  assign fetch_we_o  = 1'b0;
  assign fetch_dat_o = '0;

  assign redir_pc_al = redir_pc_i & PC_ALIGN;
  assign bus_done    = (state == FETCH_REQ) && (fetch_ack_i || fetch_err_i);

  // occupancy plus the one fetch that may still be on the bus
  assign reserve   = {1'b0, count} + (CW+1)'((state == FETCH_REQ) && !discard);
  assign launch_ok = (reserve < (CW+1)'(DEPTH)) && !redir_i;

  assign push = bus_done && !discard && !redir_i;
  assign pop  = ins_valid_o && ins_ready_i && !redir_i;

  always_comb begin
    push_entry     = '0;
    push_entry.pc  = pc;
    if (fetch_err_i)
      push_entry.err = 1'b1;
    else
      push_entry.ins = fetch_dat_i;
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .flush     (redir_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign ins_valid_o = (count != '0);
  assign ins_o       = head.ins;
  assign ins_pc_o    = head.pc;
  assign ins_err_o   = head.err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= FETCH_IDLE;
      pc          <= PC_RST;
      discard     <= 1'b0;
      fetch_cyc_o <= 1'b0;
      fetch_adr_o <= '0;
    end else begin
      unique case (state)
        // the gap cycle makes the launch decision itself, so back-to-back
        // fetches run stb/ack/gap with no extra idle cycle
        FETCH_IDLE, FETCH_GAP: begin
          fetch_cyc_o <= 1'b0;
          state       <= FETCH_IDLE;
          if (redir_i) begin
            pc <= redir_pc_al;
          end else if (launch_ok) begin
            state       <= FETCH_REQ;
            fetch_cyc_o <= 1'b1;
            fetch_adr_o <= pc;
          end
        end
        FETCH_REQ: begin
          if (redir_i)
            pc <= redir_pc_al;
          if (bus_done) begin
            fetch_cyc_o <= 1'b0;
            discard     <= 1'b0;
            if (redir_i || discard) begin
              state <= FETCH_GAP;
            end else if (fetch_err_i) begin
              state <= FETCH_FAULT;
            end else begin
              pc    <= pc + PC_STEP;
              state <= FETCH_GAP;
            end
          end else if (redir_i) begin
            discard <= 1'b1;
          end
        end
        FETCH_FAULT: begin
          fetch_cyc_o <= 1'b0;
          if (redir_i) begin
            pc    <= redir_pc_al;
            state <= FETCH_IDLE;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM slave model plus directed scenarios and a randomized
// run checked against an instruction-stream reference model.
module tb_fetch_unit;

  localparam int AW = 16;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_cyc_o, fetch_stb_o, fetch_we_o;
  logic [AW-1:0] fetch_adr_o;
  logic [DW-1:0] fetch_dat_o, fetch_dat_i;
  logic          fetch_ack_i, fetch_err_i;
  logic          ins_valid_o;
  logic [DW-1:0] ins_o;
  logic [AW-1:0] ins_pc_o;
  logic          ins_err_o;
  logic          ins_ready_i = 1'b0;
  logic          redir_i = 1'b0;
  logic [AW-1:0] redir_pc_i = '0;

  always #5 clk = ~clk;

  fetch_unit #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .RESET_PC(0), .DEPTH(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .fetch_cyc_o(fetch_cyc_o), .fetch_stb_o(fetch_stb_o), .fetch_we_o(fetch_we_o),
    .fetch_adr_o(fetch_adr_o), .fetch_dat_o(fetch_dat_o), .fetch_dat_i(fetch_dat_i),
    .fetch_ack_i(fetch_ack_i), .fetch_err_i(fetch_err_i),
    .ins_valid_o(ins_valid_o), .ins_o(ins_o), .ins_pc_o(ins_pc_o), .ins_err_o(ins_err_o),
    .ins_ready_i(ins_ready_i), .redir_i(redir_i), .redir_pc_i(redir_pc_i)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- ROM slave: ack one cycle after stb, rearms on stb low
  logic          ack_r, err_r, rearm;
  int            wcnt;
  int            wait_max = 0;
  bit            err_en = 1'b0;
  logic [AW-1:0] err_adr = '0;
  bit            rand_err = 1'b0;
  bit [63:0]     err_tbl = '0;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return {16'hC0DE, a, ~a, a ^ 16'h5A5A};
  endfunction

  function automatic bit slave_err(input logic [AW-1:0] a);
    return (err_en && a == err_adr) || (rand_err && err_tbl[a[8:3]]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0; err_r <= 1'b0; rearm <= 1'b1; wcnt <= 0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      if (!fetch_stb_o) begin
        rearm <= 1'b1;
      end else if (rearm) begin
        if (wcnt > 0) wcnt <= wcnt - 1;
        else begin
          rearm <= 1'b0;
          if (slave_err(fetch_adr_o)) err_r <= 1'b1;
          else                        ack_r <= 1'b1;
          wcnt <= (wait_max > 0) ? int'($urandom_range(wait_max, 0)) : 0;
        end
      end
    end
  end

  assign fetch_ack_i = ack_r & fetch_stb_o;
  assign fetch_err_i = err_r & fetch_stb_o;
  assign fetch_dat_i = rom(fetch_adr_o);

  // bus port invariants every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (fetch_stb_o !== fetch_cyc_o || fetch_we_o !== 1'b0 || fetch_dat_o !== '0) begin
        errors++;
        $display("FAIL bus_static: stb=%b cyc=%b we=%b dat_o=%h want stb==cyc we=0 dat_o=0",
                 fetch_stb_o, fetch_cyc_o, fetch_we_o, fetch_dat_o);
      end
    end
  end

  // ---------------- cycle helpers (observation only)
  int            cyc_n;
  logic          prev_cyc;
  bit            rise;
  bit            popped;
  logic [AW-1:0] pop_pc;
  logic [DW-1:0] pop_ins;
  logic          pop_err;

  task automatic step();
    @(negedge clk);
    cyc_n++;
    rise     = fetch_cyc_o && !prev_cyc;
    prev_cyc = fetch_cyc_o;
  endtask

  // inputs set here take effect at the next rising edge; record the handshake it will make
  task automatic drive(input bit rdy, input bit rd, input logic [AW-1:0] tgt);
    ins_ready_i = rdy;
    redir_i     = rd;
    redir_pc_i  = tgt;
    popped  = ins_valid_o && rdy && !rd;
    pop_pc  = ins_pc_o;
    pop_ins = ins_o;
    pop_err = ins_err_o;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ins_ready_i = 1'b0; redir_i = 1'b0; redir_pc_i = '0;
    err_en = 1'b0; rand_err = 1'b0; wait_max = 0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    cyc_n    = 0;
    prev_cyc = fetch_cyc_o;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fetch_cyc_o, fetch_stb_o, fetch_we_o, ins_valid_o, ins_err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cyc/stb/we/valid/err=%b want 00000",
               {fetch_cyc_o, fetch_stb_o, fetch_we_o, ins_valid_o, ins_err_o});
    end
    checks++;
    if (fetch_adr_o !== '0 || ins_pc_o !== '0 || ins_o !== '0) begin
      errors++;
      $display("FAIL reset_data: adr=%h pc=%h ins=%h want all 0", fetch_adr_o, ins_pc_o, ins_o);
    end
  endtask

  task automatic test_latency();
    int rc[$]; logic [AW-1:0] ra[$];
    int first_v = -1; logic [AW-1:0] fv_pc = '0; logic [DW-1:0] fv_ins = '0;
    do_reset();
    repeat (9) begin
      drive(1'b1, 1'b0, '0);
      step();
      if (rise) begin rc.push_back(cyc_n); ra.push_back(fetch_adr_o); end
      if (ins_valid_o && first_v < 0) begin first_v = cyc_n; fv_pc = ins_pc_o; fv_ins = ins_o; end
    end
    checks++;
    if (rc.size() < 3) begin
      errors++;
      $display("FAIL lat_nreq: %0d requests want >=3", rc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rc[i] != 1 + 3*i || ra[i] !== AW'(8*i)) begin
          errors++;
          $display("FAIL lat_req%0d: cycle %0d adr %h want cycle %0d adr %h", i, rc[i], ra[i], 1+3*i, 8*i);
        end
      end
    end
    checks++;
    if (first_v != 3 || fv_pc !== '0 || fv_ins !== rom('0)) begin
      errors++;
      $display("FAIL lat_valid: cycle %0d pc %h ins %h want cycle 3 pc 0 ins %h", first_v, fv_pc, fv_ins, rom('0));
    end
  endtask

  task automatic test_stall();
    int nf = 0; logic [AW-1:0] pp[$]; logic [DW-1:0] pd[$]; logic [AW-1:0] res_adr = 'x; bit got = 0;
    do_reset();
    repeat (20) begin drive(1'b0, 1'b0, '0); step(); if (rise) nf++; end
    checks++;
    if (nf != 2 || fetch_cyc_o !== 1'b0 || ins_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_pause: fetches %0d cyc %b valid %b want 2 0 1", nf, fetch_cyc_o, ins_valid_o);
    end
    for (int k = 0; k < 20 && !got; k++) begin
      drive(1'b1, 1'b0, '0);
      if (popped) begin pp.push_back(pop_pc); pd.push_back(pop_ins); end
      step();
      if (rise) begin res_adr = fetch_adr_o; got = 1; end
    end
    checks++;
    if (pp.size() < 2 || pp[0] !== 16'h0 || pp[1] !== 16'h8 || pd[0] !== rom(16'h0) || pd[1] !== rom(16'h8)) begin
      errors++;
      $display("FAIL stall_order: %0d pops first pcs %h %h want 0000 0008 with rom data",
               pp.size(), (pp.size() > 0) ? pp[0] : 16'hxxxx, (pp.size() > 1) ? pp[1] : 16'hxxxx);
    end
    checks++;
    if (res_adr !== 16'h10) begin
      errors++;
      $display("FAIL stall_resume: adr %h want 0010", res_adr);
    end
  endtask

  task automatic test_redirect();
    bit found = 0, bad = 0, got = 0, gotp = 0;
    logic [AW-1:0] radr = 'x, padr = 'x; logic [DW-1:0] pins = 'x;
    do_reset();
    for (int k = 0; k < 30 && !found; k++) begin
      drive(1'b1, 1'b0, '0); step();
      if (rise && fetch_adr_o == 16'h10) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL redir_find: no request at 0010 within 30 cycles"); end
    drive(1'b1, 1'b1, 16'h48); step();
    for (int k = 0; k < 20 && !gotp; k++) begin
      drive(1'b1, 1'b0, '0);
      if (popped) begin
        if (pop_pc == 16'h10) bad = 1;
        else begin padr = pop_pc; pins = pop_ins; gotp = 1; end
      end
      step();
      if (rise && !got) begin radr = fetch_adr_o; got = 1; end
    end
    checks++;
    if (bad) begin errors++; $display("FAIL redir_discard: 0010 reached decode, want dropped"); end
    checks++;
    if (radr !== 16'h48 || padr !== 16'h48 || pins !== rom(16'h48)) begin
      errors++;
      $display("FAIL redir_target: adr %h pop pc %h want 0048 0048", radr, padr);
    end
    got = 0; gotp = 0; radr = 'x; padr = 'x;
    drive(1'b1, 1'b1, 16'h4d); step();
    for (int k = 0; k < 20 && !gotp; k++) begin
      drive(1'b1, 1'b0, '0);
      if (popped) begin padr = pop_pc; gotp = 1; end
      step();
      if (rise && !got) begin radr = fetch_adr_o; got = 1; end
    end
    checks++;
    if (radr !== 16'h48 || padr !== 16'h48) begin
      errors++;
      $display("FAIL redir_align: adr %h pop pc %h want 0048 0048", radr, padr);
    end
  endtask

  task automatic test_fault();
    int np = 0; bit faulted = 0, busy = 0, got = 0, gotp = 0;
    logic [AW-1:0] radr = 'x, padr = 'x; logic perr = 1'bx;
    do_reset();
    err_en = 1'b1; err_adr = 16'h18;
    for (int k = 0; k < 40 && !faulted; k++) begin
      drive(1'b1, 1'b0, '0);
      if (popped) begin
        checks++;
        if (pop_pc !== AW'(8*np) || pop_err !== (np == 3) || pop_ins !== ((np == 3) ? '0 : rom(AW'(8*np)))) begin
          errors++;
          $display("FAIL fault_seq%0d: pc %h err %b ins %h want pc %h err %b", np, pop_pc, pop_err, pop_ins, 8*np, np == 3);
        end
        if (pop_err) faulted = 1;
        np++;
      end
      step();
    end
    checks++;
    if (!faulted || np != 4) begin errors++; $display("FAIL fault_entry: %0d pops faulted %b want 4 1", np, faulted); end
    repeat (10) begin drive(1'b1, 1'b0, '0); step(); if (fetch_cyc_o || ins_valid_o) busy = 1; end
    checks++;
    if (busy) begin errors++; $display("FAIL fault_idle: bus or buffer active after fault, want quiet"); end
    err_en = 1'b0;
    drive(1'b1, 1'b1, 16'h0); step();
    for (int k = 0; k < 20 && !gotp; k++) begin
      drive(1'b1, 1'b0, '0);
      if (popped) begin padr = pop_pc; perr = pop_err; gotp = 1; end
      step();
      if (rise && !got) begin radr = fetch_adr_o; got = 1; end
    end
    checks++;
    if (radr !== 16'h0 || padr !== 16'h0 || perr !== 1'b0) begin
      errors++;
      $display("FAIL fault_restart: adr %h pop pc %h err %b want 0000 0000 0", radr, padr, perr);
    end
  endtask

  task automatic test_async_reset();
    bit found = 0, got = 0; int rcyc = -1; logic [AW-1:0] radr = 'x;
    do_reset();
    for (int k = 0; k < 20 && !found; k++) begin
      drive(1'b0, 1'b0, '0); step();
      if (fetch_cyc_o && ins_valid_o) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL areset_find: no REQ with valid head within 20 cycles"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (fetch_cyc_o !== 1'b0 || fetch_stb_o !== 1'b0 || ins_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_drop: cyc %b stb %b valid %b want 0 0 0", fetch_cyc_o, fetch_stb_o, ins_valid_o);
    end
    @(negedge clk);
    rst_n = 1'b1; cyc_n = 0; prev_cyc = fetch_cyc_o;
    for (int k = 0; k < 4 && !got; k++) begin
      drive(1'b0, 1'b0, '0); step();
      if (rise) begin rcyc = cyc_n; radr = fetch_adr_o; got = 1; end
    end
    checks++;
    if (rcyc != 1 || radr !== 16'h0) begin
      errors++;
      $display("FAIL areset_restart: cycle %0d adr %h want cycle 1 adr 0000", rcyc, radr);
    end
  endtask

  task automatic test_wrap_full();
    logic [AW-1:0] ra[$]; logic [AW-1:0] pp[$]; logic [DW-1:0] pd[$];
    logic [AW-1:0] e;
    do_reset();
    drive(1'b1, 1'b1, 16'hFFF8); step();
    for (int k = 0; k < 40; k++) begin
      drive(k >= 12, 1'b0, '0);
      if (popped) begin pp.push_back(pop_pc); pd.push_back(pop_ins); end
      step();
      if (rise) ra.push_back(fetch_adr_o);
    end
    checks++;
    if (ra.size() < 2 || ra[0] !== 16'hFFF8 || ra[1] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_adr: %0d requests, want first two FFF8 0000", ra.size());
    end
    checks++;
    if (pp.size() < 4) begin
      errors++;
      $display("FAIL full_count: %0d pops want >=4", pp.size());
    end else begin
      e = 16'hFFF8;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pp[i] !== e || pd[i] !== rom(e)) begin
          errors++;
          $display("FAIL full_seq%0d: pc %h ins %h want pc %h ins %h", i, pp[i], pd[i], e, rom(e));
        end
        e = e + 16'h8;
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_pc = '0; bit faulted = 0; int npops = 0;
    bit rdy, rd; logic [AW-1:0] tgt; bit e_err;
    do_reset();
    rand_err = 1'b1; wait_max = 2;
    err_tbl  = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
    for (int k = 0; k < 3000; k++) begin
      rdy = ($urandom_range(3, 0) != 0);
      rd  = ($urandom_range(24, 0) == 0) || (faulted && $urandom_range(4, 0) == 0);
      tgt = ($urandom_range(3, 0) == 0) ? 16'hFFE0 + AW'($urandom_range(31, 0)) : AW'($urandom);
      drive(rdy, rd, tgt);
      if (rd) begin
        exp_pc  = tgt & 16'hFFF8;
        faulted = 0;
      end else if (popped) begin
        checks++;
        e_err = err_tbl[exp_pc[8:3]];
        if (faulted) begin
          errors++;
          $display("FAIL rand_after_fault: pc %h popped, want nothing until redirect", pop_pc);
        end else if (pop_pc !== exp_pc || pop_err !== e_err || pop_ins !== (e_err ? '0 : rom(exp_pc))) begin
          errors++;
          $display("FAIL rand_stream: pc %h err %b ins %h want pc %h err %b ins %h",
                   pop_pc, pop_err, pop_ins, exp_pc, e_err, e_err ? '0 : rom(exp_pc));
        end
        if (e_err) faulted = 1;
        else       exp_pc = exp_pc + 16'h8;
        npops++;
      end
      step();
    end
    checks++;
    if (npops < 100) begin errors++; $display("FAIL rand_progress: %0d pops want >=100", npops); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_redirect();
    test_fault();
    test_async_reset();
    test_wrap_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
